gpu_mmu_arbiter: RTL and testbench
==================================

// Module: gpu_mmu_arbiter
// PURPOSE
//  Shares one base/bound translation datapath between NUM_REQ shader cores.
//  - Holds a per-core context table (base, bound) written by the command processor.
//  - Arbitrates core requests round-robin and translates one address per cycle.
//  - Returns a registered response (physical addr or bound fault) tagged with the core id.
// PARAMETERS
//  ADDR_WIDTH  32  virtual/physical address width
//  NUM_REQ     4   number of requesting cores (>=2)
//  ID_WIDTH    $clog2(NUM_REQ)  requester id width (derived, localparam)
// PORTS
//  clk            in   1                    clock
//  rst_n          in   1                    async active-low reset
//  i_req_valid    in   NUM_REQ              per-core request valid
//  i_req_vaddr    in   NUM_REQ*ADDR_WIDTH   per-core virtual addr; core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  o_req_ready    out  NUM_REQ              one-hot grant; request k accepted when valid[k] & ready[k]
//  o_rsp_valid    out  1                    response valid
//  o_rsp_id       out  ID_WIDTH             core id of response
//  o_rsp_paddr    out  ADDR_WIDTH           base + vaddr; forced to 0 on fault
//  o_rsp_error    out  1                    bound fault
//  i_rsp_ready    in   1                    response consumed
//  i_cfg_we       in   1                    context write strobe
//  i_cfg_id       in   ID_WIDTH             context to write
//  i_cfg_base     in   ADDR_WIDTH           new base
//  i_cfg_bound    in   ADDR_WIDTH           new bound (exclusive limit)
// BEHAVIOUR
//  Clocking: single clock clk; rst_n asynchronous, active-low.
//  Reset: o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_paddr=0, o_rsp_error=0.
//    Reset also clears all contexts to base=0, bound=0, so every translation faults until configured.
//    RR pointer resets to 0.
//  Accept condition: slot_free = !o_rsp_valid | i_rsp_ready.
//    With slot_free and any valid, exactly one ready bit is set (combinational from valid and pointer).
//    With no valid or no free slot, o_req_ready=0.
//  Arbitration: round-robin starting at the pointer, searching pointer, pointer+1, ... mod NUM_REQ.
//    After an accepted grant to k, the pointer becomes (k+1) mod NUM_REQ.
//    The pointer holds when nothing is accepted.
//  Latency: request accepted in cycle N -> o_rsp_valid in cycle N+1.
//    Response registers are loaded only on accept.
//    With i_rsp_ready=1 every cycle, throughput is one translation per cycle.
//  Hold: while o_rsp_valid & !i_rsp_ready, all response outputs are held stable.
//    o_rsp_valid clears after a handshake with no new accept.
//  Translation:
//    error = (vaddr >= bound), unsigned compare.
//    paddr = (base + vaddr) truncated to ADDR_WIDTH; wrap is not a fault.
//    On fault, paddr = 0.
//  Config: a write in cycle N updates the context at cycle N+1.
//    A request for the same id accepted in cycle N uses the old context.
//    i_cfg_id >= NUM_REQ is ignored. Config writes never stall requests.
//  Requester side may drop valid without a grant; no fairness credit is retained.
// CONFIGURATION
//  Macro GPU_MMU_FAULT_LOG_EN.
//  Defined: adds the following ports:
//    o_fault_valid  out  1           sticky fault flag
//    o_fault_id     out  ID_WIDTH    core id of first fault
//    o_fault_vaddr  out  ADDR_WIDTH  vaddr of first fault
//    i_fault_clear  in   1           clears the log
//  Fault log capture:
//    The first faulting accept sets o_fault_valid and captures id and vaddr.
//    Later faults do not overwrite while o_fault_valid=1.
//    i_fault_clear clears o_fault_valid next cycle.
//    Clear and a new fault in the same cycle: the new fault is captured (valid stays 1).
//    All fault-log outputs reset to 0.
//  Undefined: fault-log ports and logic are absent; the remaining behaviour is identical.
// STRUCTURE
//  Package gpu_mmu_pkg:
//    typedef mmu_ctx_t {base, bound} (ADDR_WIDTH-parameterised via package param or macro width)
//    function mmu_translate(ctx, vaddr) returning {paddr, error}
//  Sub-module gpu_rr_arbiter #(NUM_REQ):
//    req vector and advance strobe -> one-hot grant; owns the pointer.
//  Top level: context table, response register stage, optional fault log.
// TESTING
//  1 Reset, no config; core 0 req vaddr=0x10
//      -> rsp N+1: id=0, error=1, paddr=0.
//  2 cfg id1 base=0x1000_0000 bound=0x100; core1 vaddr=0xFF then 0x100
//      -> paddr=0x1000_00FF err=0; then err=1, paddr=0.
//  3 All 4 cores valid continuously, rsp_ready=1
//      -> grants 0,1,2,3,0,... one per cycle; each id appears once per 4 responses.
//  4 rsp_ready=0 for 3 cycles after first response
//      -> outputs stable, o_req_ready=0 throughout; on release the next grant is core1.
//  5 base=0xFFFF_FFF0 bound=0x100, vaddr=0x20 -> paddr=0x0000_0010, err=0 (wrap).
//    cfg write and accept for same id in same cycle -> old context used.
//  6 (GPU_MMU_FAULT_LOG_EN) faults from core2 vaddr=0x40, then core3
//      -> log holds id=2, vaddr=0x40.
//    Clear together with a new fault -> log holds the new fault.
//  Mid-operation reset asserted with o_rsp_valid=1 -> all outputs 0 asynchronously; contexts cleared.

Source files
------------

// File: rtl/gpu_mmu_pkg.sv
// gpu_mmu_pkg: shared types and the base/bound translation function for gpu_mmu_arbiter.
//   mmu_ctx_t     per-core context {base, bound}; bound is an exclusive limit
//   mmu_xlat_t    translation result {paddr, error}
//   mmu_translate fault when vaddr >= bound; otherwise paddr = base + vaddr (wraps silently)
// MmuAddrWidth fixes the context width; gpu_mmu_arbiter's ADDR_WIDTH must equal it.
package gpu_mmu_pkg;

   localparam int unsigned MmuAddrWidth = 32;

   typedef struct packed {
      logic [MmuAddrWidth-1:0] base;
      logic [MmuAddrWidth-1:0] bound;
   } mmu_ctx_t;

   typedef struct packed {
      logic [MmuAddrWidth-1:0] paddr;
      logic                    error;
   } mmu_xlat_t;

   function automatic mmu_xlat_t mmu_translate(input mmu_ctx_t               ctx,
                                               input logic [MmuAddrWidth-1:0] vaddr);
      mmu_xlat_t res;
      res.error = (vaddr >= ctx.bound);
      // Faulting translations never leak a physical address.
      res.paddr = res.error ? '0 : ctx.base + vaddr;
      return res;
   endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// gpu_rr_arbiter: round-robin one-hot arbiter that owns the priority pointer.
//   clk, rst_n   clock, async active-low reset (pointer resets to 0)
//   req          request vector; the search starts at the pointer and wraps
//   advance      grant was taken this cycle; pointer moves past the winner
//   grant        one-hot grant (zero when no request)
//   grant_id     binary index of the granted requester
module gpu_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int unsigned IdWidth = $clog2(NUM_REQ);

   logic [IdWidth-1:0] ptr_q, ptr_d;
   logic [IdWidth-1:0] idx;
   logic               found;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = IdWidth'((32'(ptr_q) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = IdWidth'((32'(grant_id) + 1) % NUM_REQ);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/gpu_mmu_arbiter.sv
// gpu_mmu_arbiter: shares one base/bound translator between NUM_REQ shader cores.
//   clk, rst_n            clock, async active-low reset
//   i_req_valid/vaddr     per-core requests; core k vaddr at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_req_ready           one-hot grant, only when the response slot is free
//   o_rsp_*               registered response (id, paddr, error), held until i_rsp_ready
//   i_cfg_*               context table write port; ids >= NUM_REQ are ignored
// Optional GPU_MMU_FAULT_LOG_EN adds a sticky first-fault log
//   (o_fault_valid, o_fault_id, o_fault_vaddr, i_fault_clear).
// ADDR_WIDTH must match gpu_mmu_pkg::MmuAddrWidth.
module gpu_mmu_arbiter
   import gpu_mmu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MmuAddrWidth,
   parameter int unsigned NUM_REQ    = 4,
   localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_vaddr,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic                        o_rsp_valid,
   output logic [ID_WIDTH-1:0]         o_rsp_id,
   output logic [ADDR_WIDTH-1:0]       o_rsp_paddr,
   output logic                        o_rsp_error,
   input  logic                        i_rsp_ready,
`ifdef GPU_MMU_FAULT_LOG_EN
   output logic                        o_fault_valid,
   output logic [ID_WIDTH-1:0]         o_fault_id,
   output logic [ADDR_WIDTH-1:0]       o_fault_vaddr,
   input  logic                        i_fault_clear,
`endif
   input  logic                        i_cfg_we,
   input  logic [ID_WIDTH-1:0]         i_cfg_id,
   input  logic [ADDR_WIDTH-1:0]       i_cfg_base,
   input  logic [ADDR_WIDTH-1:0]       i_cfg_bound
);

   mmu_ctx_t              ctx_q [NUM_REQ];

   logic                  slot_free;
   logic [NUM_REQ-1:0]    req_elig;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_WIDTH-1:0]   grant_id;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_vaddr;
   mmu_xlat_t             xlat;
   logic                  cfg_hit;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [ID_WIDTH-1:0]   rsp_id_q;
   logic [ADDR_WIDTH-1:0] rsp_paddr_q;
   logic                  rsp_error_q;

   assign slot_free = !rsp_valid_q || i_rsp_ready;
   // Gating with rst_n keeps o_req_ready low while reset is held, not just after it.
   assign req_elig  = i_req_valid & {NUM_REQ{slot_free & rst_n}};

   gpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_elig),
      .advance  (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign accept      = |grant;
   assign o_req_ready = grant;

   always_comb begin
      sel_vaddr = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_vaddr = i_req_vaddr[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Reads the registered table, so a same-cycle config write is seen only by later requests.
   assign xlat    = mmu_translate(ctx_q[grant_id], sel_vaddr);
   assign cfg_hit = i_cfg_we && (32'(i_cfg_id) < NUM_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            ctx_q[k] <= '0;
         end
      end else if (cfg_hit) begin
         ctx_q[i_cfg_id] <= '{base: i_cfg_base, bound: i_cfg_bound};
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
      end else if (i_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_paddr_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (accept) begin
            rsp_id_q    <= grant_id;
            rsp_paddr_q <= xlat.paddr;
            rsp_error_q <= xlat.error;
         end
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_paddr = rsp_paddr_q;
   assign o_rsp_error = rsp_error_q;

`ifdef GPU_MMU_FAULT_LOG_EN
   logic                  fault_valid_q;
   logic [ID_WIDTH-1:0]   fault_id_q;
   logic [ADDR_WIDTH-1:0] fault_vaddr_q;
   logic                  fault_new;

   assign fault_new = accept && xlat.error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_valid_q <= 1'b0;
         fault_id_q    <= '0;
         fault_vaddr_q <= '0;
      end else if (fault_new && (!fault_valid_q || i_fault_clear)) begin
         // A clear racing a new fault still records the new fault.
         fault_valid_q <= 1'b1;
         fault_id_q    <= grant_id;
         fault_vaddr_q <= sel_vaddr;
      end else if (i_fault_clear) begin
         fault_valid_q <= 1'b0;
      end
   end

   assign o_fault_valid = fault_valid_q;
   assign o_fault_id    = fault_id_q;
   assign o_fault_vaddr = fault_vaddr_q;
`endif

endmodule

// File: tb/tb_gpu_mmu_arbiter.sv
module tb_gpu_mmu_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*AW-1:0] req_vaddr = '0;
   logic [NR-1:0]    o_req_ready;
   logic             o_rsp_valid;
   logic [1:0]       o_rsp_id;
   logic [AW-1:0]    o_rsp_paddr;
   logic             o_rsp_error;
   logic             rsp_ready = 1'b0;
   logic             cfg_we = 1'b0;
   logic [1:0]       cfg_id = '0;
   logic [AW-1:0]    cfg_base = '0;
   logic [AW-1:0]    cfg_bound = '0;
`ifdef GPU_MMU_FAULT_LOG_EN
   logic             o_fault_valid;
   logic [1:0]       o_fault_id;
   logic [AW-1:0]    o_fault_vaddr;
   logic             fault_clear = 1'b0;
`endif

   always #5 clk = ~clk;

   gpu_mmu_arbiter #(
      .ADDR_WIDTH (AW),
      .NUM_REQ    (NR)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .i_req_vaddr   (req_vaddr),
      .o_req_ready   (o_req_ready),
      .o_rsp_valid   (o_rsp_valid),
      .o_rsp_id      (o_rsp_id),
      .o_rsp_paddr   (o_rsp_paddr),
      .o_rsp_error   (o_rsp_error),
      .i_rsp_ready   (rsp_ready),
`ifdef GPU_MMU_FAULT_LOG_EN
      .o_fault_valid (o_fault_valid),
      .o_fault_id    (o_fault_id),
      .o_fault_vaddr (o_fault_vaddr),
      .i_fault_clear (fault_clear),
`endif
      .i_cfg_we      (cfg_we),
      .i_cfg_id      (cfg_id),
      .i_cfg_base    (cfg_base),
      .i_cfg_bound   (cfg_bound)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: context table, RR pointer and the pending response.
   logic [AW-1:0] m_base [NR];
   logic [AW-1:0] m_bound [NR];
   int            m_ptr;
   logic          m_valid;
   logic [1:0]    m_id;
   logic [AW-1:0] m_paddr;
   logic          m_err;
   logic          m_fv;
   logic [1:0]    m_fid;
   logic [AW-1:0] m_fva;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_base[i]  = '0;
         m_bound[i] = '0;
      end
      m_ptr = 0; m_valid = 0; m_id = 0; m_paddr = 0; m_err = 0;
      m_fv = 0; m_fid = 0; m_fva = 0;
   endtask

   function automatic int m_winner();
      if (!rst_n) return -1;
      if (m_valid && !rsp_ready) return -1;
      for (int i = 0; i < NR; i++) begin
         int k = (m_ptr + i) % NR;
         if (req_valid[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] m_grant();
      int w = m_winner();
      logic [NR-1:0] g = '0;
      if (w >= 0) g[w] = 1'b1;
      return g;
   endfunction

   task automatic model_step();
      int w = m_winner();
      logic clr = 1'b0;
`ifdef GPU_MMU_FAULT_LOG_EN
      clr = fault_clear;
`endif
      if (w >= 0) begin
         logic [AW-1:0] v = req_vaddr[w*AW +: AW];
         m_valid = 1;
         m_id    = 2'(w);
         m_err   = (v >= m_bound[w]);
         m_paddr = m_err ? '0 : m_base[w] + v;
         m_ptr   = (w + 1) % NR;
         if (m_err && (!m_fv || clr)) begin
            m_fv = 1; m_fid = 2'(w); m_fva = v;
         end else if (clr) begin
            m_fv = 0;
         end
      end else begin
         if (rsp_ready) m_valid = 0;
         if (clr) m_fv = 0;
      end
      if (cfg_we) begin
         m_base[cfg_id]  = cfg_base;
         m_bound[cfg_id] = cfg_bound;
      end
   endtask

   always @(negedge rst_n) model_reset();
   always @(posedge clk) if (rst_n) model_step();

   always @(negedge clk) begin
      check("cyc_req_ready", 64'(o_req_ready), 64'(m_grant()));
      check("cyc_rsp_valid", 64'(o_rsp_valid), 64'(m_valid));
      check("cyc_rsp_id", 64'(o_rsp_id), 64'(m_id));
      check("cyc_rsp_paddr", 64'(o_rsp_paddr), 64'(m_paddr));
      check("cyc_rsp_error", 64'(o_rsp_error), 64'(m_err));
`ifdef GPU_MMU_FAULT_LOG_EN
      check("cyc_fault_valid", 64'(o_fault_valid), 64'(m_fv));
      check("cyc_fault_id", 64'(o_fault_id), 64'(m_fid));
      check("cyc_fault_vaddr", 64'(o_fault_vaddr), 64'(m_fva));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] v);
      req_valid[k] = 1'b1;
      req_vaddr[k*AW +: AW] = v;
   endtask

   task automatic cfg(input logic [1:0] id, input logic [AW-1:0] b, input logic [AW-1:0] bd);
      cfg_we = 1'b1; cfg_id = id; cfg_base = b; cfg_bound = bd;
   endtask

   task automatic chk_rsp(input string name, input logic [1:0] id, input logic [AW-1:0] pa,
                          input logic err);
      check({name, "_valid"}, 64'(o_rsp_valid), 64'd1);
      check({name, "_id"}, 64'(o_rsp_id), 64'(id));
      check({name, "_paddr"}, 64'(o_rsp_paddr), 64'(pa));
      check({name, "_error"}, 64'(o_rsp_error), 64'(err));
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state.
      check("rst_ready", 64'(o_req_ready), 64'd0);
      check("rst_valid", 64'(o_rsp_valid), 64'd0);
      check("rst_paddr", 64'(o_rsp_paddr), 64'd0);

      // 1: unconfigured context always faults.
      rsp_ready = 1'b1;
      set_req(0, 32'h10);
      #1 check("t1_ready", 64'(o_req_ready), 64'b0001);
      tick();
      req_valid = '0;
      chk_rsp("t1", 2'd0, 32'h0, 1'b1);
      tick();

      // 3: all cores valid after a fresh reset -> strict rotation.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < NR; k++) set_req(k, 32'(k * 16));
      for (int c = 0; c < 8; c++) begin
         tick();
         check("t3_id", 64'(o_rsp_id), 64'(c % NR));
      end
      req_valid = '0;
      tick();

      // 4: back-pressure holds outputs and blocks grants.
      for (int k = 0; k < NR; k++) set_req(k, 32'h4);
      tick();
      chk_rsp("t4_first", 2'd0, 32'h0, 1'b1);
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 check("t4_hold_ready", 64'(o_req_ready), 64'd0);
         tick();
         chk_rsp("t4_hold", 2'd0, 32'h0, 1'b1);
      end
      rsp_ready = 1'b1;
      #1 check("t4_release_ready", 64'(o_req_ready), 64'b0010);
      tick();
      chk_rsp("t4_next", 2'd1, 32'h0, 1'b1);
      req_valid = '0;
      tick();

      // 2: bound edge on core 1.
      cfg(2'd1, 32'h1000_0000, 32'h100);
      tick();
      cfg_we = 1'b0;
      set_req(1, 32'hFF);
      tick();
      chk_rsp("t2_in", 2'd1, 32'h1000_00FF, 1'b0);
      set_req(1, 32'h100);
      tick();
      chk_rsp("t2_edge", 2'd1, 32'h0, 1'b1);
      req_valid = '0;
      tick();
      check("t2_drain", 64'(o_rsp_valid), 64'd0);

      // 5: address wrap, and same-cycle config uses the old context.
      cfg(2'd2, 32'hFFFF_FFF0, 32'h100);
      tick();
      cfg_we = 1'b0;
      set_req(2, 32'h20);
      tick();
      chk_rsp("t5_wrap", 2'd2, 32'h0000_0010, 1'b0);
      set_req(2, 32'h30);
      cfg(2'd2, 32'h2000, 32'h1000);
      tick();
      cfg_we = 1'b0;
      chk_rsp("t5_oldctx", 2'd2, 32'h0000_0020, 1'b0);
      tick();
      chk_rsp("t5_newctx", 2'd2, 32'h0000_2030, 1'b0);
      req_valid = '0;
      tick();

`ifdef GPU_MMU_FAULT_LOG_EN
      // 6: sticky first-fault log.
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      check("t6_cleared", 64'(o_fault_valid), 64'd0);
      cfg(2'd2, 32'h0, 32'h10);
      tick();
      cfg_we = 1'b0;
      set_req(2, 32'h40);
      tick();
      req_valid = '0;
      set_req(3, 32'h55);
      tick();
      req_valid = '0;
      tick();
      check("t6_fv", 64'(o_fault_valid), 64'd1);
      check("t6_fid", 64'(o_fault_id), 64'd2);
      check("t6_fva", 64'(o_fault_vaddr), 64'h40);
      fault_clear = 1'b1;
      set_req(3, 32'h77);
      tick();
      fault_clear = 1'b0;
      req_valid = '0;
      check("t6_race_fv", 64'(o_fault_valid), 64'd1);
      check("t6_race_fid", 64'(o_fault_id), 64'd3);
      check("t6_race_fva", 64'(o_fault_vaddr), 64'h77);
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      check("t6_clear_fv", 64'(o_fault_valid), 64'd0);
`endif

      // Mid-operation reset with a pending response.
      set_req(0, 32'h5);
      tick();
      check("mr_pending", 64'(o_rsp_valid), 64'd1);
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mr_ready", 64'(o_req_ready), 64'd0);
      check("mr_valid", 64'(o_rsp_valid), 64'd0);
      check("mr_id", 64'(o_rsp_id), 64'd0);
      check("mr_paddr", 64'(o_rsp_paddr), 64'd0);
      check("mr_error", 64'(o_rsp_error), 64'd0);
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      set_req(1, 32'h0);
      tick();
      req_valid = '0;
      chk_rsp("mr_ctx_cleared", 2'd1, 32'h0, 1'b1);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
